// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with HI/LO result registers.
// Sits directly downstream of the register file and serves MULT/MULTU/DIV/DIVU.
// Results land in Hi/Lo only when an operation finishes. MTHI/MTLO can write
// Hi/Lo directly through BusW.
//
// Ports:
//   Clk        clock; all state changes on the rising edge
//   Rst        synchronous active-high reset; overrides everything
//   Start      begin an operation (sampled only while idle)
//   Op[1:0]    00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   BusA       multiplicand / dividend
//   BusB       multiplier / divisor
//   BusW       write data for MTHI/MTLO
//   HiWr/LoWr  write BusW into Hi/Lo (ignored while Busy)
//   Busy       operation in progress (registered)
//   Done       one-cycle pulse: Hi/Lo were updated on this edge
//   Hi/Lo      upper product / remainder, lower product / quotient
//
// state  | meaning
// S_IDLE | waiting for Start; MTHI/MTLO writes allowed
// S_MUL  | shift-add, one multiplier bit per cycle
// S_DIV  | restoring divide, one quotient bit per cycle
// S_FIN  | sign correction and Hi/Lo write, Done pulse
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] BusA,
   input  logic [WIDTH-1:0] BusB,
   input  logic [WIDTH-1:0] BusW,
   input  logic             HiWr,
   input  logic             LoWr,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

   state_t state_q, state_d;

   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] acc_hi_q;
   logic [WIDTH-1:0] acc_lo_q;
   logic [WIDTH-1:0] opb_q;
   logic [WIDTH-1:0] raw_a_q;
   logic             neg_lo_q;
   logic             neg_hi_q;
   logic             is_div_q;
   logic             div_zero_q;

   // operand magnitudes; the unsigned WIDTH-bit negate of the most negative
   // value is exact, so 0x80000000 needs no extra handling
   logic             signed_op, a_neg, b_neg;
   logic [WIDTH-1:0] mag_a, mag_b;

   always_comb begin
      signed_op = ~Op[0];
      a_neg     = signed_op & BusA[WIDTH-1];
      b_neg     = signed_op & BusB[WIDTH-1];
      mag_a     = a_neg ? -BusA : BusA;
      mag_b     = b_neg ? -BusB : BusB;
   end

   // multiply step: acc_lo holds the remaining multiplier bits, the product
   // grows into acc_hi from the top and the pair is shifted right each cycle
   logic [WIDTH:0]   mul_sum;
   // divide step: acc_hi is the partial remainder, acc_lo shifts the dividend
   // out and the quotient in
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_diff;

   always_comb begin
      mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
      div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
      div_ge    = div_shift >= {1'b0, opb_q};
      div_diff  = div_shift[WIDTH-1:0] - opb_q;
   end

   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;

   always_comb begin
      prod     = {acc_hi_q, acc_lo_q};
      prod_fix = neg_lo_q ? -prod : prod;
      quo_fix  = neg_lo_q ? -acc_lo_q : acc_lo_q;
      rem_fix  = neg_hi_q ? -acc_hi_q : acc_hi_q;
      if (div_zero_q) begin
         res_hi = raw_a_q;
         res_lo = '1;
      end else if (is_div_q) begin
         res_hi = rem_fix;
         res_lo = quo_fix;
      end else begin
         res_hi = prod_fix[2*WIDTH-1:WIDTH];
         res_lo = prod_fix[WIDTH-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (Start) state_d = Op[1] ? S_DIV : S_MUL;
         S_MUL:   if (cnt_q == '0) state_d = S_FIN;
         S_DIV:   if (div_zero_q || cnt_q == '0) state_d = S_FIN;
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= S_IDLE;
         Busy    <= 1'b0;
         Done    <= 1'b0;
      end else begin
         state_q <= state_d;
         Busy    <= (state_d != S_IDLE);
         Done    <= (state_q == S_FIN);
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         cnt_q      <= '0;
         acc_hi_q   <= '0;
         acc_lo_q   <= '0;
         opb_q      <= '0;
         raw_a_q    <= '0;
         neg_lo_q   <= 1'b0;
         neg_hi_q   <= 1'b0;
         is_div_q   <= 1'b0;
         div_zero_q <= 1'b0;
         Hi         <= '0;
         Lo         <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (HiWr) Hi <= BusW;
               if (LoWr) Lo <= BusW;
               if (Start) begin
                  cnt_q      <= CNT_LOAD;
                  acc_hi_q   <= '0;
                  acc_lo_q   <= mag_a;
                  opb_q      <= mag_b;
                  raw_a_q    <= BusA;
                  neg_lo_q   <= a_neg ^ b_neg;
                  neg_hi_q   <= a_neg;
                  is_div_q   <= Op[1];
                  div_zero_q <= Op[1] && (BusB == '0);
               end
            end
            S_MUL: begin
               acc_hi_q <= mul_sum[WIDTH:1];
               acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
               cnt_q    <= cnt_q - CW'(1);
            end
            S_DIV: begin
               if (!div_zero_q) begin
                  acc_hi_q <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                  acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_ge};
                  cnt_q    <= cnt_q - CW'(1);
               end
            end
            S_FIN: begin
               Hi <= res_hi;
               Lo <= res_lo;
            end
            default: ;
         endcase
      end
   end

endmodule
